// File: rtl/fetch_redirect_if.sv
// Instruction-memory request/response bus for the fetch stage.
//   ImemReq   : fetch request valid (fetch -> memory)
//   ImemAddr  : fetch address       (fetch -> memory)
//   ImemReady : memory accepts the request this cycle (memory -> fetch)
//   ImemValid : response data valid (memory -> fetch)
//   ImemRData : response instruction word (memory -> fetch)
// master = fetch unit side, slave = instruction memory side.
interface fetch_redirect_if #(
  parameter int WIDTH = 32
);
  logic             ImemReq;
  logic [WIDTH-1:0] ImemAddr;
  logic             ImemReady;
  logic             ImemValid;
  logic [WIDTH-1:0] ImemRData;

  modport master (
    output ImemReq, ImemAddr,
    input  ImemReady, ImemValid, ImemRData
  );

  modport slave (
    input  ImemReq, ImemAddr,
    output ImemReady, ImemValid, ImemRData
  );
endinterface

// File: rtl/fetch_redirect.sv
// Fetch-stage PC and instruction-request unit for the MIPS pipeline.
// Issues one outstanding instruction-memory request at a time, owns the
// IF/ID register and squashes wrong-path fetches on a taken redirect.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   StallF, StallD    : hazard-unit stalls (no new request / hold IF/ID)
//   PCSrcD, PCBranchD : decode-stage redirect request and target
//   imem              : instruction-memory bus (master side)
//   PCF               : current fetch PC
//   InstrD, PCPlus4D  : IF/ID instruction and its PC+4
//   ValidD            : InstrD holds a real instruction (0 = bubble)
module fetch_redirect #(
  parameter int                WIDTH    = 32,
  parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               StallF,
  input  logic               StallD,
  input  logic               PCSrcD,
  input  logic [WIDTH-1:0]   PCBranchD,
  fetch_redirect_if.master   imem,
  output logic [WIDTH-1:0]   PCF,
  output logic [WIDTH-1:0]   InstrD,
  output logic [WIDTH-1:0]   PCPlus4D,
  output logic               ValidD
);

  typedef enum logic [1:0] {ISSUE, WAIT, FULL} state_t;

  localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

  state_t           state;
  logic             kill;
  logic [WIDTH-1:0] pcReq;
  logic [WIDTH-1:0] instrBuf;

  logic accept;
  logic redirect;

  // Request is a pure function of state/StallF/PCF; reset only masks it.
  assign imem.ImemReq  = (state == ISSUE) && !StallF && !reset;
  assign imem.ImemAddr = PCF;

  assign accept   = imem.ImemReq && imem.ImemReady;
  assign redirect = PCSrcD && ValidD && !StallD;

  always_ff @(posedge clk) begin
    if (reset) begin
      PCF      <= RESET_PC;
      state    <= ISSUE;
      kill     <= 1'b0;
      pcReq    <= '0;
      instrBuf <= '0;
      InstrD   <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else begin
      // Bubble by default when D advances; a delivery below overrides it.
      if (!StallD) ValidD <= 1'b0;

      unique case (state)
        ISSUE: begin
          if (accept) begin
            pcReq <= PCF;
            PCF   <= PCF + FOUR;
            state <= WAIT;
            if (redirect) kill <= 1'b1;
          end
        end
        WAIT: begin
          if (imem.ImemValid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= ISSUE;
            end else if (redirect) begin
              state <= ISSUE;
            end else if (!StallD) begin
              InstrD   <= imem.ImemRData;
              PCPlus4D <= pcReq + FOUR;
              ValidD   <= 1'b1;
              state    <= ISSUE;
            end else begin
              instrBuf <= imem.ImemRData;
              state    <= FULL;
            end
          end else if (redirect) begin
            kill <= 1'b1;
          end
        end
        FULL: begin
          if (redirect) begin
            state <= ISSUE;
          end else if (!StallD) begin
            InstrD   <= instrBuf;
            PCPlus4D <= pcReq + FOUR;
            ValidD   <= 1'b1;
            state    <= ISSUE;
          end
        end
        default: state <= ISSUE;
      endcase

      // Redirect wins over the PC+4 and any delivery made above.
      if (redirect) begin
        PCF    <= PCBranchD;
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_redirect.sv
module tb_fetch_redirect;

  logic        clk = 1'b0;
  logic        reset, reset2;
  logic        StallF, StallD, PCSrcD;
  logic [31:0] PCBranchD;
  logic [31:0] PCF, InstrD, PCPlus4D;
  logic        ValidD;
  logic        zero1;
  logic [31:0] zero32;
  logic [31:0] PCF2, InstrD2, PCPlus4D2;
  logic        ValidD2;

  int unsigned total = 0;
  int unsigned passed = 0;

  always #5 clk = ~clk;

  fetch_redirect_if #(.WIDTH(32)) bus ();
  fetch_redirect_if #(.WIDTH(32)) bus2 ();

  fetch_redirect #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD),
    .PCSrcD(PCSrcD), .PCBranchD(PCBranchD), .imem(bus),
    .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  fetch_redirect #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
    .clk(clk), .reset(reset2), .StallF(zero1), .StallD(zero1),
    .PCSrcD(zero1), .PCBranchD(zero32), .imem(bus2),
    .PCF(PCF2), .InstrD(InstrD2), .PCPlus4D(PCPlus4D2), .ValidD(ValidD2)
  );

  typedef struct {
    logic        rst, sF, sD, pcs;
    logic [31:0] br;
    logic        rdy, vld;
    logic [31:0] rd;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eV;
    logic [31:0] eI, eP;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic void add(
    input logic rst, input logic sF, input logic sD, input logic pcs,
    input logic [31:0] br, input logic rdy, input logic vld, input logic [31:0] rd,
    input logic eReq, input logic [31:0] eAddr,
    input logic eV, input logic [31:0] eI, input logic [31:0] eP);
    vec_t v;
    v.rst = rst; v.sF = sF; v.sD = sD; v.pcs = pcs; v.br = br;
    v.rdy = rdy; v.vld = vld; v.rd = rd;
    v.eReq = eReq; v.eAddr = eAddr; v.eV = eV; v.eI = eI; v.eP = eP;
    vecs.push_back(v);
  endfunction

  initial begin
    //   rst sF sD pcs br        rdy vld rd            req addr       V  InstrD        PCPlus4D
    // sequential fetch
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h000,    0, 32'h0,        32'h000);
    add(0, 0, 0, 0, 32'h0,     1, 1, 32'h20080001, 0, 32'h004,    1, 32'h20080001, 32'h004);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h004,    0, 32'h20080001, 32'h004);
    add(0, 0, 0, 0, 32'h0,     1, 1, 32'h20080002, 0, 32'h008,    1, 32'h20080002, 32'h008);
    // redirect to 0x100 in the same cycle as accept of 0x8
    add(0, 0, 0, 1, 32'h100,   1, 0, 32'h0,        1, 32'h008,    0, 32'h20080002, 32'h008);
    add(0, 0, 0, 0, 32'h0,     1, 1, 32'h20080003, 0, 32'h100,    0, 32'h20080002, 32'h008);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h100,    0, 32'h20080002, 32'h008);
    add(0, 0, 0, 0, 32'h0,     1, 1, 32'h8C010000, 0, 32'h104,    1, 32'h8C010000, 32'h104);
    // StallD on response -> FULL, release later
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h104,    0, 32'h8C010000, 32'h104);
    add(0, 0, 1, 0, 32'h0,     1, 1, 32'hDEADBEEF, 0, 32'h108,    0, 32'h8C010000, 32'h104);
    add(0, 0, 1, 0, 32'h0,     1, 0, 32'h0,        0, 32'h108,    0, 32'h8C010000, 32'h104);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,        0, 32'h108,    1, 32'hDEADBEEF, 32'h108);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h108,    0, 32'hDEADBEEF, 32'h108);
    // PCSrcD with ValidD=0 is ignored
    add(0, 0, 0, 1, 32'h500,   1, 1, 32'h11111111, 0, 32'h10C,    1, 32'h11111111, 32'h10C);
    // PCSrcD under StallD ignored, then redirect while FULL
    add(0, 0, 1, 1, 32'h500,   1, 0, 32'h0,        1, 32'h10C,    1, 32'h11111111, 32'h10C);
    add(0, 0, 1, 1, 32'h500,   1, 1, 32'h22222222, 0, 32'h110,    1, 32'h11111111, 32'h10C);
    add(0, 0, 0, 1, 32'h200,   1, 0, 32'h0,        0, 32'h110,    0, 32'h11111111, 32'h10C);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h200,    0, 32'h11111111, 32'h10C);
    add(0, 0, 0, 0, 32'h0,     1, 1, 32'h33333333, 0, 32'h204,    1, 32'h33333333, 32'h204);
    // redirect in WAIT, late response 3 cycles later is killed
    add(0, 0, 1, 0, 32'h0,     1, 0, 32'h0,        1, 32'h204,    1, 32'h33333333, 32'h204);
    add(0, 0, 0, 1, 32'h300,   1, 0, 32'h0,        0, 32'h208,    0, 32'h33333333, 32'h204);
    add(0, 0, 0, 1, 32'h700,   1, 0, 32'h0,        0, 32'h300,    0, 32'h33333333, 32'h204);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,        0, 32'h300,    0, 32'h33333333, 32'h204);
    add(0, 0, 0, 0, 32'h0,     1, 1, 32'h44444444, 0, 32'h300,    0, 32'h33333333, 32'h204);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h300,    0, 32'h33333333, 32'h204);
    add(0, 0, 0, 0, 32'h0,     1, 1, 32'h55555555, 0, 32'h304,    1, 32'h55555555, 32'h304);
    // StallF suppresses the request
    add(0, 1, 0, 0, 32'h0,     1, 0, 32'h0,        0, 32'h304,    0, 32'h55555555, 32'h304);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h304,    0, 32'h55555555, 32'h304);
    // reset while in WAIT, stray response afterwards is ignored
    add(1, 0, 0, 0, 32'h0,     1, 0, 32'h0,        0, 32'h308,    0, 32'h0,        32'h0);
    add(0, 0, 0, 0, 32'h0,     0, 1, 32'h66666666, 1, 32'h000,    0, 32'h0,        32'h0);
    add(0, 0, 0, 0, 32'h0,     1, 0, 32'h0,        1, 32'h000,    0, 32'h0,        32'h0);

    zero1 = 1'b0; zero32 = '0;
    reset = 1'b1; reset2 = 1'b1;
    StallF = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = '0;
    bus.ImemReady = 1'b0; bus.ImemValid = 1'b0; bus.ImemRData = '0;
    bus2.ImemReady = 1'b0; bus2.ImemValid = 1'b0; bus2.ImemRData = '0;

    // reset state
    @(negedge clk); #1;
    chk("reset_req", {31'b0, bus.ImemReq}, 32'h0);
    @(posedge clk); #1;
    chk("reset_pcf", PCF, 32'h0);
    chk("reset_validD", {31'b0, ValidD}, 32'h0);
    chk("reset_instrD", InstrD, 32'h0);
    chk("reset_pcplus4D", PCPlus4D, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clk);
      reset         = vecs[i].rst;
      StallF        = vecs[i].sF;
      StallD        = vecs[i].sD;
      PCSrcD        = vecs[i].pcs;
      PCBranchD     = vecs[i].br;
      bus.ImemReady = vecs[i].rdy;
      bus.ImemValid = vecs[i].vld;
      bus.ImemRData = vecs[i].rd;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, bus.ImemReq}, {31'b0, vecs[i].eReq});
      chk($sformatf("v%0d_addr", i), bus.ImemAddr, vecs[i].eAddr);
      @(posedge clk); #1;
      chk($sformatf("v%0d_validD", i), {31'b0, ValidD}, {31'b0, vecs[i].eV});
      chk($sformatf("v%0d_instrD", i), InstrD, vecs[i].eI);
      chk($sformatf("v%0d_pcplus4D", i), PCPlus4D, vecs[i].eP);
    end

    // PC wrap with RESET_PC = 0xFFFFFFFC
    @(negedge clk);
    reset2 = 1'b0;
    bus2.ImemReady = 1'b1;
    #1;
    chk("wrap_req0", {31'b0, bus2.ImemReq}, 32'h1);
    chk("wrap_addr0", bus2.ImemAddr, 32'hFFFF_FFFC);
    @(negedge clk);
    bus2.ImemValid = 1'b1;
    bus2.ImemRData = 32'hABCD0001;
    #1;
    chk("wrap_waitreq", {31'b0, bus2.ImemReq}, 32'h0);
    chk("wrap_pcf", PCF2, 32'h0);
    @(posedge clk); #1;
    chk("wrap_validD", {31'b0, ValidD2}, 32'h1);
    chk("wrap_instrD", InstrD2, 32'hABCD0001);
    chk("wrap_pcplus4D", PCPlus4D2, 32'h0);
    @(negedge clk);
    bus2.ImemValid = 1'b0;
    #1;
    chk("wrap_req1", {31'b0, bus2.ImemReq}, 32'h1);
    chk("wrap_addr1", bus2.ImemAddr, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
